// File: rtl/adder_issuer.sv
// adder_issuer: queues operand pairs, issues them one at a time to a fixed-latency adder,
// and returns the captured sum with a mismatch flag against a locally computed reference.
module adder_issuer #(
  parameter int W     = 4,
  parameter int CW    = 7,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  output logic          add_valid,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  input  logic [CW-1:0] add_c,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [CW-1:0] rsp_c,
  output logic          rsp_err,
  output logic          busy,
  output logic [15:0]   txn_cnt,
  output logic [7:0]    err_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LCW = $clog2(LAT + 1);

  if (CW < W + 1) begin : g_cw_check
    $error("adder_issuer: CW must be at least W+1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("adder_issuer: DEPTH must be a power of 2 and at least 2");
  end
  if (LAT < 1) begin : g_lat_check
    $error("adder_issuer: LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [W-1:0]   fifo_a [DEPTH];
  logic [W-1:0]   fifo_b [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push, pop;
  logic [W-1:0]   head_a, head_b;
  logic [CW-1:0]  exp_sum;
  logic [LCW-1:0] wait_cnt;

  assign cmd_ready = (count != (AW + 1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_a    = fifo_a[rd_ptr];
  assign head_b    = fifo_b[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  // Storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= cmd_a;
      fifo_b[wr_ptr] <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_cnt == LCW'(1)) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The reference sum is taken from the popped operands so it travels with the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      exp_sum   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
      txn_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            add_valid <= 1'b1;
            add_a     <= head_a;
            add_b     <= head_b;
            exp_sum   <= CW'(head_a) + CW'(head_b);
          end
        end
        ISSUE: begin
          add_valid <= 1'b0;
          wait_cnt  <= LCW'(LAT);
        end
        WAIT: begin
          wait_cnt <= wait_cnt - LCW'(1);
          if (wait_cnt == LCW'(1)) begin
            rsp_c     <= add_c;
            rsp_err   <= (add_c != exp_sum);
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_cnt   <= txn_cnt + 16'd1;
            if (rsp_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
